// File: rtl/seq_detect_sched.sv
// Round-robin scheduler feeding CH serial streams into one shared Moore pattern detector.
// Optional SEQ_DETECT_SCHED_MATCH_CNT_EN adds a saturating 16-bit match counter (match_total).
module seq_detect_sched #(
    parameter int unsigned CH      = 4,
    parameter int unsigned PLEN    = 3,
    parameter int unsigned OVERLAP = 1,
    localparam int unsigned CW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            cfg_we,
    input  logic [PLEN-1:0] cfg_pattern,
    input  logic [CH-1:0]   req,
    input  logic [CH-1:0]   bit_in,
    output logic [CH-1:0]   gnt,
    output logic            match,
    output logic [CW-1:0]   match_ch,
    output logic [PLEN-1:0] pattern
`ifdef SEQ_DETECT_SCHED_MATCH_CNT_EN
    ,
    output logic [15:0]     match_total
`endif
);

    localparam int unsigned CNTW = $clog2(PLEN + 1);
    localparam logic [PLEN-1:0] PatRst = PLEN'(3'b101);

    logic [PLEN-1:0] pattern_q;
    logic [PLEN-1:0] hist_q [CH];
    logic [CNTW-1:0] cnt_q [CH];
    logic [CW-1:0]   rr_ptr_q;
    logic            match_q;
    logic [CW-1:0]   match_ch_q;

    logic            gnt_vld;
    logic [CW-1:0]   gnt_idx;
    logic [CW-1:0]   scan_idx;
    logic [PLEN-1:0] cand;
    logic            hit;
    logic [CW-1:0]   rr_ptr_nxt;

    // Scan upward from rr_ptr with wrap; the first pending requester wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        if (!reset && en && !cfg_we) begin
            for (int i = 0; i < int'(CH); i++) begin
                scan_idx = CW'((int'(rr_ptr_q) + i) % int'(CH));
                if (!gnt_vld && req[scan_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_vld) begin
            gnt = CH'(1) << gnt_idx;
        end
    end

    always_comb begin
        cand       = {hist_q[gnt_idx][PLEN-2:0], bit_in[gnt_idx]};
        hit        = gnt_vld && (cand == pattern_q) && (cnt_q[gnt_idx] >= CNTW'(PLEN - 1));
        rr_ptr_nxt = (gnt_idx == CW'(CH - 1)) ? '0 : gnt_idx + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q  <= PatRst;
            rr_ptr_q   <= '0;
            match_q    <= 1'b0;
            match_ch_q <= '0;
            for (int k = 0; k < int'(CH); k++) begin
                hist_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else if (cfg_we) begin
            pattern_q <= cfg_pattern;
            match_q   <= 1'b0;
            for (int k = 0; k < int'(CH); k++) begin
                hist_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else if (!en) begin
            match_q <= 1'b0;
        end else begin
            match_q <= hit;
            if (hit) begin
                match_ch_q <= gnt_idx;
            end
            if (gnt_vld) begin
                rr_ptr_q <= rr_ptr_nxt;
            end
            for (int k = 0; k < int'(CH); k++) begin
                if (gnt_vld && gnt_idx == CW'(k)) begin
                    if (hit && OVERLAP == 0) begin
                        hist_q[k] <= '0;
                        cnt_q[k]  <= '0;
                    end else begin
                        hist_q[k] <= cand;
                        if (cnt_q[k] < CNTW'(PLEN)) begin
                            cnt_q[k] <= cnt_q[k] + CNTW'(1);
                        end
                    end
                end
            end
        end
    end

`ifdef SEQ_DETECT_SCHED_MATCH_CNT_EN
    logic [15:0] match_total_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_total_q <= '0;
        end else if (cfg_we) begin
            match_total_q <= '0;
        end else if (match_q && match_total_q != 16'hFFFF) begin
            match_total_q <= match_total_q + 16'd1;
        end
    end

    assign match_total = match_total_q;
`endif

    assign match    = match_q;
    assign match_ch = match_ch_q;
    assign pattern  = pattern_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched: one overlapping and one non-overlapping instance
// share the same stimulus; expected match results are queued per consuming edge.
module tb_seq_detect_sched;

    logic       clk;
    logic       reset;
    logic       en;
    logic       cfg_we;
    logic [2:0] cfg_pattern;
    logic [3:0] req;
    logic [3:0] bit_in;
    logic [3:0] gnt;
    logic [3:0] gnt0;
    logic       match;
    logic       match0;
    logic [1:0] match_ch;
    logic [1:0] match_ch0;
    logic [2:0] pattern;
    logic [2:0] pattern0;
`ifdef SEQ_DETECT_SCHED_MATCH_CNT_EN
    logic [15:0] match_total;
    logic [15:0] match_total0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       m1;
        logic [1:0] ch;
        logic       m0;
    } exp_t;
    exp_t exp_q[$];

    seq_detect_sched #(.CH(4), .PLEN(3), .OVERLAP(1)) dut (
        .clk(clk), .reset(reset), .en(en), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .req(req), .bit_in(bit_in), .gnt(gnt), .match(match), .match_ch(match_ch),
        .pattern(pattern)
`ifdef SEQ_DETECT_SCHED_MATCH_CNT_EN
        , .match_total(match_total)
`endif
    );

    seq_detect_sched #(.CH(4), .PLEN(3), .OVERLAP(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .req(req), .bit_in(bit_in), .gnt(gnt0), .match(match0), .match_ch(match_ch0),
        .pattern(pattern0)
`ifdef SEQ_DETECT_SCHED_MATCH_CNT_EN
        , .match_total(match_total0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, check the combinational grant, queue the expected
    // match, take the edge, then pop and compare the registered result.
    task automatic cycle(input logic e, input logic cw, input logic [2:0] cp,
                         input logic [3:0] r, input logic [3:0] b, input logic [3:0] exp_gnt,
                         input logic em1, input logic [1:0] ech, input logic em0);
        exp_t ex;
        exp_t got;
        en = e;
        cfg_we = cw;
        cfg_pattern = cp;
        req = r;
        bit_in = b;
        #1;
        checks++;
        if (gnt !== exp_gnt || gnt0 !== exp_gnt) begin
            errors++;
            $display("FAIL gnt: got %b/%b expected %b at %0t", gnt, gnt0, exp_gnt, $time);
        end
        ex.m1 = em1;
        ex.ch = ech;
        ex.m0 = em0;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            got = exp_q.pop_front();
            if (match !== got.m1 || (got.m1 && match_ch !== got.ch)) begin
                errors++;
                $display("FAIL match_ov1: got %b ch %0d expected %b ch %0d at %0t",
                         match, match_ch, got.m1, got.ch, $time);
            end
            if (match0 !== got.m0 || (got.m0 && match_ch0 !== got.ch)) begin
                errors++;
                $display("FAIL match_ov0: got %b ch %0d expected %b ch %0d at %0t",
                         match0, match_ch0, got.m0, got.ch, $time);
            end
        end
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic apply_reset();
        en = 1'b1;
        cfg_we = 1'b0;
        cfg_pattern = 3'b000;
        req = 4'b1111;
        bit_in = 4'b0000;
        reset = 1'b1;
        #3;
        checks++;
        if (gnt !== 4'b0000 || gnt0 !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt: got %b/%b expected 0000", gnt, gnt0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        req = 4'b0000;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (match !== 1'b0 || match_ch !== 2'd0 || pattern !== 3'b101 ||
            match0 !== 1'b0 || pattern0 !== 3'b101) begin
            errors++;
            $display("FAIL reset_state: match %b ch %0d pattern %b expected 0 0 101",
                     match, match_ch, pattern);
        end
    endtask

    // Includes an en=0 cycle that must not consume the pending bit.
    task automatic test_basic();
        cycle(1'b0, 1'b0, 3'b000, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 1'b0, 3'b000, 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 1'b0, 3'b000, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 1'b0, 3'b000, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1);
        idle();
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [6];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001; seq[5] = 4'b0010;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 3'b000, 4'b1111, 4'b0000, seq[i], 1'b0, 2'd0, 1'b0);
        end
    endtask

    task automatic test_overlap();
        logic [4:0] bits;
        logic [4:0] exp1;
        logic [4:0] exp0;
        bits = 5'b10101;
        exp1 = 5'b00101;
        exp0 = 5'b00100;
        apply_reset();
        for (int i = 4; i >= 0; i--) begin
            cycle(1'b1, 1'b0, 3'b000, 4'b0010, {2'b00, bits[i], 1'b0}, 4'b0010,
                  exp1[i], 2'd1, exp0[i]);
        end
        idle();
`ifdef SEQ_DETECT_SCHED_MATCH_CNT_EN
        checks++;
        if (match_total !== 16'd2 || match_total0 !== 16'd1) begin
            errors++;
            $display("FAIL match_total: got %0d/%0d expected 2/1", match_total, match_total0);
        end
`endif
    endtask

    task automatic test_interleave();
        logic [2:0] ch0_bits;
        logic [2:0] ch2_bits;
        logic       b;
        ch0_bits = 3'b101;
        ch2_bits = 3'b111;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                b = ch0_bits[2 - i / 2];
                cycle(1'b1, 1'b0, 3'b000, 4'b0101, {3'b010, b}, 4'b0001,
                      i == 4, 2'd0, i == 4);
            end else begin
                b = ch2_bits[2 - i / 2];
                cycle(1'b1, 1'b0, 3'b000, 4'b0101, {1'b0, b, 2'b01}, 4'b0100,
                      1'b0, 2'd0, 1'b0);
            end
        end
    endtask

    task automatic test_config();
        logic [5:0] bits;
        logic [5:0] expm;
        bits = 6'b110101;
        expm = 6'b001000;
        apply_reset();
        cycle(1'b1, 1'b1, 3'b110, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
        checks++;
        if (pattern !== 3'b110 || pattern0 !== 3'b110) begin
            errors++;
            $display("FAIL cfg_pattern: got %b/%b expected 110", pattern, pattern0);
        end
        for (int i = 5; i >= 0; i--) begin
            cycle(1'b1, 1'b0, 3'b000, 4'b0001, {3'b000, bits[i]}, 4'b0001,
                  expm[i], 2'd0, expm[i]);
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        cycle(1'b1, 1'b0, 3'b000, 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 1'b0, 3'b000, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0);
        req = 4'b0000;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        checks++;
        if (match !== 1'b0 || pattern !== 3'b101) begin
            errors++;
            $display("FAIL async_reset: match %b pattern %b expected 0 101", match, pattern);
        end
`ifdef SEQ_DETECT_SCHED_MATCH_CNT_EN
        checks++;
        if (match_total !== 16'd0 || match_total0 !== 16'd0) begin
            errors++;
            $display("FAIL match_total_reset: got %0d/%0d expected 0", match_total, match_total0);
        end
`endif
        @(posedge clk);
        #1;
        // Pointer back at 0 and partial history gone: the third bit must not match.
        cycle(1'b1, 1'b0, 3'b000, 4'b1111, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0);
        idle();
    endtask

    initial begin
        reset = 1'b0;
        en = 1'b0;
        cfg_we = 1'b0;
        cfg_pattern = 3'b000;
        req = 4'b0000;
        bit_in = 4'b0000;
        #1;
        test_reset();
        test_basic();
        test_round_robin();
        test_overlap();
        test_interleave();
        test_config();
        test_reset_midstream();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
